// File: rtl/multi_delayer.sv
// rtl/multi_delayer.sv - multi-channel round-robin token delayer with per-channel flush
module multi_delayer #(
    parameter int                    FLUX       = 2,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    DEPTH      = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0,
    localparam int                   TAG_WIDTH  = (FLUX > 1) ? $clog2(FLUX) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [FLUX-1:0]                 in_empty,
    input  logic [FLUX*DATA_WIDTH-1:0]      in_dout,
    output logic [FLUX-1:0]                 in_read,
    input  logic [FLUX-1:0]                 flush_req,
    input  logic                            out_full,
    output logic                            out_write,
    output logic [TAG_WIDTH+DATA_WIDTH-1:0] out_din
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem_q [FLUX][DEPTH];
    logic [PTR_W-1:0]      ptr_q [FLUX];
    logic [PTR_W-1:0]      ptr_d [FLUX];
    logic [TAG_WIDTH-1:0]  rr_last_q;
    logic [TAG_WIDTH-1:0]  rr_last_d;

    logic [FLUX-1:0]       eligible;
    logic [FLUX-1:0]       grant_oh;
    logic                  grant_valid;
    logic [TAG_WIDTH-1:0]  grant_idx;
    logic [DATA_WIDTH-1:0] grant_data;
    logic                  fire;
    int                    scan_idx;

    // A flushing channel is masked so its pending head token stays in its input FIFO.
    assign eligible = ~in_empty & ~flush_req;

    // Round-robin scan starting just after the last served channel.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        grant_oh    = '0;
        grant_data  = '0;
        scan_idx    = 0;
        for (int i = 1; i <= FLUX; i++) begin
            scan_idx = (int'(rr_last_q) + i) % FLUX;
            if (!grant_valid && eligible[scan_idx]) begin
                grant_valid        = 1'b1;
                grant_idx          = TAG_WIDTH'(scan_idx);
                grant_oh[scan_idx] = 1'b1;
                grant_data         = mem_q[scan_idx][ptr_q[scan_idx]];
            end
        end
    end

    // Outputs are gated by reset so they fall immediately when rst drops.
    assign fire      = grant_valid && !out_full && rst;
    assign out_write = fire;
    assign in_read   = fire ? grant_oh : '0;
    assign out_din   = fire ? {grant_idx, grant_data} : '0;

    // Next-state for per-channel write pointers (wrap at DEPTH-1) and the arbiter history.
    always_comb begin
        for (int c = 0; c < FLUX; c++) begin
            ptr_d[c] = (ptr_q[c] == PTR_W'(DEPTH - 1)) ? '0 : ptr_q[c] + 1'b1;
        end
        rr_last_d = fire ? grant_idx : rr_last_q;
    end

    // Buffer, pointer and arbiter state; flush and fire never target the same channel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < FLUX; c++) begin
                for (int d = 0; d < DEPTH; d++) begin
                    mem_q[c][d] <= INIT_VAL;
                end
                ptr_q[c] <= '0;
            end
            rr_last_q <= TAG_WIDTH'(FLUX - 1);
        end else begin
            for (int c = 0; c < FLUX; c++) begin
                if (flush_req[c]) begin
                    for (int d = 0; d < DEPTH; d++) begin
                        mem_q[c][d] <= INIT_VAL;
                    end
                    ptr_q[c] <= '0;
                end else if (fire && grant_oh[c]) begin
                    mem_q[c][ptr_q[c]] <= in_dout[c*DATA_WIDTH +: DATA_WIDTH];
                    ptr_q[c]           <= ptr_d[c];
                end
            end
            rr_last_q <= rr_last_d;
        end
    end

endmodule

// File: tb/tb_multi_delayer.sv
// tb/tb_multi_delayer.sv - directed self-checking bench for multi_delayer
module tb_multi_delayer;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  in_empty, flush_req, in_read;
    logic [15:0] in_dout;
    logic        out_full, out_write;
    logic [8:0]  out_din;

    logic [1:0]  in_empty5, flush_req5, in_read5;
    logic [15:0] in_dout5;
    logic        out_full5, out_write5;
    logic [8:0]  out_din5;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_delayer #(.FLUX(2), .DATA_WIDTH(8), .DEPTH(3), .INIT_VAL(8'd0)) dut3 (
        .clk(clk), .rst(rst), .in_empty(in_empty), .in_dout(in_dout), .in_read(in_read),
        .flush_req(flush_req), .out_full(out_full), .out_write(out_write), .out_din(out_din)
    );

    multi_delayer #(.FLUX(2), .DATA_WIDTH(8), .DEPTH(5), .INIT_VAL(8'd0)) dut5 (
        .clk(clk), .rst(rst), .in_empty(in_empty5), .in_dout(in_dout5), .in_read(in_read5),
        .flush_req(flush_req5), .out_full(out_full5), .out_write(out_write5), .out_din(out_din5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle on the DEPTH=3 instance: drive after negedge, check combinational outputs.
    task automatic cyc3(input string tag, input logic [1:0] empty, input logic [7:0] d0,
                        input logic [7:0] d1, input logic [1:0] flush, input logic full,
                        input logic exp_wr, input logic [1:0] exp_rd, input logic [8:0] exp_din);
        @(negedge clk);
        in_empty  = empty;
        in_dout   = {d1, d0};
        flush_req = flush;
        out_full  = full;
        #1;
        chk($sformatf("%s_wr", tag), 32'(out_write), 32'(exp_wr));
        chk($sformatf("%s_rd", tag), 32'(in_read), 32'(exp_rd));
        chk($sformatf("%s_din", tag), 32'(out_din), 32'(exp_din));
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_empty  = 2'b11;
        in_empty5 = 2'b11;
        flush_req = 2'b00;
        out_full  = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0] exp_data [8];
        rst        = 1'b0;
        in_empty   = 2'b00;
        in_dout    = {8'd6, 8'd5};
        flush_req  = 2'b00;
        out_full   = 1'b0;
        in_empty5  = 2'b00;
        in_dout5   = {8'd6, 8'd5};
        flush_req5 = 2'b00;
        out_full5  = 1'b0;

        // Reset: outputs held low even with data pending
        #2;
        chk("rst_wr", 32'(out_write), 32'd0);
        chk("rst_rd", 32'(in_read), 32'd0);
        chk("rst_din", 32'(out_din), 32'd0);
        chk("rst_wr5", 32'(out_write5), 32'd0);
        @(negedge clk);
        in_empty  = 2'b11;
        in_empty5 = 2'b11;
        rst       = 1'b1;

        // 1: ch0 only, tokens 1..5 -> 0,0,0,1,2
        for (int i = 0; i < 5; i++) begin
            cyc3($sformatf("t1_%0d", i), 2'b10, 8'(i + 1), 8'd0, 2'b00, 1'b0,
                 1'b1, 2'b01, {1'b0, (i < 3) ? 8'd0 : 8'(i - 2)});
        end

        // 2: both channels busy, grants alternate starting at ch0
        do_reset();
        exp_data = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd10, 8'd20};
        for (int i = 0; i < 8; i++) begin
            cyc3($sformatf("t2_%0d", i), {1'b0, ((i + 1) / 2 >= 4) ? 1'b1 : 1'b0},
                 8'(10 + (i + 1) / 2), 8'(20 + i / 2), 2'b00, 1'b0,
                 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, {1'(i % 2), exp_data[i]});
        end

        // 3: stall for 4 cycles, then ch0 (after last served ch1) resumes from held ptr
        for (int i = 0; i < 4; i++) begin
            cyc3($sformatf("t3_stall%0d", i), 2'b00, 8'd14, 8'd24, 2'b00, 1'b1,
                 1'b0, 2'b00, 9'd0);
        end
        cyc3("t3_rel0", 2'b00, 8'd14, 8'd24, 2'b00, 1'b0, 1'b1, 2'b01, {1'b0, 8'd11});
        cyc3("t3_rel1", 2'b01, 8'd0, 8'd24, 2'b00, 1'b0, 1'b1, 2'b10, {1'b1, 8'd21});

        // 4: ch1 gets 7,8 then a flush while ch0 fires; ch1 restarts with three zeros
        do_reset();
        cyc3("t4_a", 2'b01, 8'd0, 8'd7, 2'b00, 1'b0, 1'b1, 2'b10, {1'b1, 8'd0});
        cyc3("t4_b", 2'b01, 8'd0, 8'd8, 2'b00, 1'b0, 1'b1, 2'b10, {1'b1, 8'd0});
        cyc3("t4_fl", 2'b00, 8'd50, 8'd9, 2'b10, 1'b0, 1'b1, 2'b01, {1'b0, 8'd0});
        for (int i = 0; i < 5; i++) begin
            cyc3($sformatf("t4_post%0d", i), 2'b01, 8'd0, 8'(9 + i), 2'b00, 1'b0,
                 1'b1, 2'b10, {1'b1, (i < 3) ? 8'd0 : 8'(9 + i - 3)});
        end

        // 5: DEPTH=5 instance, tokens 1..12 -> five zeros then 1..7
        in_empty = 2'b11;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            in_empty5 = 2'b10;
            in_dout5  = {8'd0, 8'(i + 1)};
            #1;
            chk($sformatf("t5_rd%0d", i), 32'(in_read5), 32'd1);
            chk($sformatf("t5_din%0d", i), 32'(out_din5),
                32'({1'b0, (i < 5) ? 8'd0 : 8'(i - 4)}));
        end
        @(negedge clk);
        in_empty5 = 2'b11;

        // 6: asynchronous reset mid-stream, then restart from INIT_VAL with ch0 first
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc3($sformatf("t6_pre%0d", i), 2'b00, 8'(30 + (i + 1) / 2), 8'(40 + i / 2),
                 2'b00, 1'b0, 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10, {1'(i % 2), 8'd0});
        end
        @(negedge clk);
        in_empty = 2'b00;
        in_dout  = {8'd42, 8'd32};
        #1;
        chk("t6_live_wr", 32'(out_write), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_wr", 32'(out_write), 32'd0);
        chk("t6_async_rd", 32'(in_read), 32'd0);
        chk("t6_async_din", 32'(out_din), 32'd0);
        @(negedge clk);
        in_empty = 2'b11;
        rst      = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cyc3($sformatf("t6_post%0d", i), 2'b00, 8'(32 + (i + 1) / 2), 8'(42 + i / 2),
                 2'b00, 1'b0, 1'b1, (i % 2 == 0) ? 2'b01 : 2'b10,
                 {1'(i % 2), (i < 6) ? 8'd0 : 8'd32});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
